elc_timer_sched: RTL and testbench



---
 rtl/elc_timer_sched.sv | 162 ++++++++++++++++
 tb/tb_elc_timer_sched.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/elc_timer_sched.sv
// elc_timer_sched: one shared down-counter serving short/long penalty timeouts
// for a bank of lock controllers, granted round-robin.
module elc_timer_sched #(
  parameter int unsigned N            = 2,
  parameter int unsigned IDW          = 1,
  parameter int unsigned CW           = 8,
  parameter int unsigned SHORT_CYCLES = 16,
  parameter int unsigned LONG_CYCLES  = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   trS,
  input  logic [N-1:0]   trL,
  input  logic [N-1:0]   cancel,
  output logic [N-1:0]   tS,
  output logic [N-1:0]   tL,
  output logic           busy,
  output logic [IDW-1:0] active_id
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CW-1:0]  SHORT_LOAD = CW'(SHORT_CYCLES - 1);
  localparam logic [CW-1:0]  LONG_LOAD  = CW'(LONG_CYCLES - 1);
  localparam logic [IDW-1:0] LAST_INIT  = IDW'(N - 1);

  // Registered state
  logic [1:0]     state;
  logic [N-1:0]   pend;
  logic [N-1:0]   kind;
  logic [CW-1:0]  cnt;
  logic [IDW-1:0] last;
  logic           akind;

  // Next-state values
  logic [1:0]     state_nxt;
  logic [N-1:0]   pend_nxt;
  logic [N-1:0]   kind_nxt;
  logic [CW-1:0]  cnt_nxt;
  logic [IDW-1:0] last_nxt;
  logic           akind_nxt;
  logic [N-1:0]   ts_nxt;
  logic [N-1:0]   tl_nxt;
  logic           busy_nxt;
  logic [IDW-1:0] aid_nxt;

  // Arbitration results
  logic [N-1:0]   req_c;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  int             scan_pos;
  logic [IDW-1:0] scan_id;

  assign req_c = trS | trL;

  // Round-robin pick: first pending index after the last one served
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    scan_pos    = 0;
    scan_id     = '0;
    for (int k = 0; k < int'(N); k++) begin
      scan_pos = int'(last) + 1 + k;
      if (scan_pos >= int'(N)) scan_pos = scan_pos - int'(N);
      scan_id = IDW'(scan_pos);
      if (!grant_valid && pend[scan_id]) begin
        grant_valid = 1'b1;
        grant_id    = scan_id;
      end
    end
  end

  // Next-state, pending latch and output decode
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    kind_nxt  = kind;
    cnt_nxt   = cnt;
    last_nxt  = last;
    akind_nxt = akind;
    aid_nxt   = active_id;
    ts_nxt    = '0;
    tl_nxt    = '0;

    // New requests override a same-cycle cancel; trL selects the long timeout
    for (int i = 0; i < int'(N); i++) begin
      if (req_c[i]) begin
        pend_nxt[i] = 1'b1;
        kind_nxt[i] = trL[i];
      end else if (cancel[i]) begin
        pend_nxt[i] = 1'b0;
      end
    end

    case (state)
      S_IDLE: begin
        if (grant_valid) begin
          state_nxt = S_COUNT;
          aid_nxt   = grant_id;
          akind_nxt = kind[grant_id];
          cnt_nxt   = kind[grant_id] ? LONG_LOAD : SHORT_LOAD;
          // A fresh request from the granted lock re-queues it
          if (!req_c[grant_id]) pend_nxt[grant_id] = 1'b0;
        end
      end
      S_COUNT: begin
        if (cancel[active_id]) begin
          state_nxt = S_IDLE;
          last_nxt  = active_id;
          aid_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt         = S_DONE;
          ts_nxt[active_id] = ~akind;
          tl_nxt[active_id] = akind;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        last_nxt  = active_id;
        aid_nxt   = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        aid_nxt   = '0;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pend      <= '0;
      kind      <= '0;
      cnt       <= '0;
      last      <= LAST_INIT;
      akind     <= 1'b0;
      tS        <= '0;
      tL        <= '0;
      busy      <= 1'b0;
      active_id <= '0;
    end else begin
      state     <= state_nxt;
      pend      <= pend_nxt;
      kind      <= kind_nxt;
      cnt       <= cnt_nxt;
      last      <= last_nxt;
      akind     <= akind_nxt;
      tS        <= ts_nxt;
      tL        <= tl_nxt;
      busy      <= busy_nxt;
      active_id <= aid_nxt;
    end
  end

endmodule

// File: tb/tb_elc_timer_sched.sv
// Scoreboard bench for elc_timer_sched: expected done pulses are queued when
// requests are driven and matched against tS/tL as they appear.
module tb_elc_timer_sched;

  localparam int N   = 2;
  localparam int IDW = 1;
  localparam int KS  = 16;
  localparam int KL  = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   trS = '0;
  logic [N-1:0]   trL = '0;
  logic [N-1:0]   cancel = '0;
  logic [N-1:0]   tS;
  logic [N-1:0]   tL;
  logic           busy;
  logic [IDW-1:0] active_id;

  typedef struct {
    int cyc;
    int id;
    bit lng;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;

  elc_timer_sched #(
    .N(N), .IDW(IDW), .CW(8), .SHORT_CYCLES(KS), .LONG_CYCLES(KL)
  ) dut (
    .clk(clk), .reset(reset), .trS(trS), .trL(trL), .cancel(cancel),
    .tS(tS), .tL(tL), .busy(busy), .active_id(active_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Match every observed done pulse against the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && ((tS | tL) != '0)) begin
      int id;
      ev_t e;
      id = -1;
      for (int i = 0; i < N; i++) if (tS[i] | tL[i]) id = i;
      chk("one_hot", 32'($countones(tS) + $countones(tL)), 32'd1);
      if (q.size() == 0) begin
        chk("unexpected_pulse", 32'(id), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
        chk("pulse_id", 32'(id), 32'(e.id));
        chk("pulse_long", {31'd0, |tL}, {31'd0, e.lng});
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    trS = '0; trL = '0; cancel = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_active_id", 32'(active_id), 32'd0);
    chk("rst_tS", 32'(tS), 32'd0);
    chk("rst_tL", 32'(tL), 32'd0);
  endtask

  // Drive one cycle of inputs; returns the cycle in which they were applied
  task automatic drive(input logic [N-1:0] s, input logic [N-1:0] l,
                       input logic [N-1:0] c, output int t);
    t = cyc;
    trS = s; trL = l; cancel = c;
    @(posedge clk); #1;
    trS = '0; trL = '0; cancel = '0;
  endtask

  task automatic sb_drained(input string tag);
    chk(tag, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int t0;
    int tx;
    @(posedge clk); #1;

    // Single short timeout on lock 0
    do_reset();
    drive(2'b01, 2'b00, 2'b00, t0);
    q.push_back('{t0 + KS + 2, 0, 1'b0});
    wait_until(t0 + 2);
    chk("s1_busy_count", {31'd0, busy}, 32'd1);
    chk("s1_active_id", 32'(active_id), 32'd0);
    wait_until(t0 + KS + 2);
    chk("s1_busy_done", {31'd0, busy}, 32'd1);
    wait_until(t0 + KS + 3);
    chk("s1_busy_after", {31'd0, busy}, 32'd0);
    wait_until(t0 + KS + 10);
    sb_drained("s1_drained");

    // Single long timeout on lock 1
    do_reset();
    drive(2'b00, 2'b10, 2'b00, t0);
    q.push_back('{t0 + KL + 2, 1, 1'b1});
    wait_until(t0 + 10);
    chk("s2_active_id", 32'(active_id), 32'd1);
    wait_until(t0 + KL + 10);
    sb_drained("s2_drained");

    // Simultaneous requests: lock 0 first, lock 1 after one idle cycle
    do_reset();
    drive(2'b01, 2'b10, 2'b00, t0);
    q.push_back('{t0 + KS + 2, 0, 1'b0});
    q.push_back('{t0 + KS + 2 + 1 + KL + 1, 1, 1'b1});
    wait_until(t0 + KS + 3);
    chk("s3_idle_gap", {31'd0, busy}, 32'd0);
    wait_until(t0 + KS + 4);
    chk("s3_grant1", 32'(active_id), 32'd1);
    wait_until(t0 + KS + KL + 10);
    sb_drained("s3_drained");

    // Round-robin: lock 1 is served before lock 0's re-request
    do_reset();
    drive(2'b01, 2'b00, 2'b00, t0);
    q.push_back('{t0 + KS + 2, 0, 1'b0});
    q.push_back('{t0 + 2 * KS + 4, 1, 1'b0});
    q.push_back('{t0 + 3 * KS + 6, 0, 1'b0});
    wait_until(t0 + 5);
    drive(2'b11, 2'b00, 2'b00, tx);
    wait_until(t0 + 3 * KS + 12);
    sb_drained("s4_drained");

    // Cancel mid-count: back to idle, no done pulse
    do_reset();
    drive(2'b01, 2'b00, 2'b00, t0);
    wait_until(t0 + 5);
    chk("s5_busy_pre", {31'd0, busy}, 32'd1);
    drive(2'b00, 2'b00, 2'b01, tx);
    chk("s5_busy_post", {31'd0, busy}, 32'd0);
    chk("s5_id_post", 32'(active_id), 32'd0);
    wait_until(t0 + KS + 10);
    sb_drained("s5_drained");

    // Reset mid-count: everything clears the next cycle, no pulse
    do_reset();
    drive(2'b00, 2'b10, 2'b00, t0);
    wait_until(t0 + 10);
    reset = 1'b1;
    wait_until(t0 + 11);
    chk("s6_busy", {31'd0, busy}, 32'd0);
    chk("s6_id", 32'(active_id), 32'd0);
    chk("s6_tS_tL", 32'(tS | tL), 32'd0);
    reset = 1'b0;
    wait_until(t0 + KL + 10);
    sb_drained("s6_drained");

    // trS and trL together on lock 0 -> long only
    do_reset();
    drive(2'b01, 2'b01, 2'b00, t0);
    q.push_back('{t0 + KL + 2, 0, 1'b1});
    wait_until(t0 + KL + 8);
    sb_drained("s7_drained");

    // Request and cancel together on lock 1 -> request is kept
    do_reset();
    drive(2'b10, 2'b00, 2'b10, t0);
    q.push_back('{t0 + KS + 2, 1, 1'b0});
    wait_until(t0 + KS + 8);
    sb_drained("s8_drained");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
